// File: rtl/bankbuff_win_pkg.sv
// rtl/bankbuff_win_pkg.sv - shared padding codes and default geometry for the row-window buffer
package bankbuff_win_pkg;

    localparam logic [1:0] BB_PAD_LEFT  = 2'b00;
    localparam logic [1:0] BB_PAD_RIGHT = 2'b01;
    localparam logic [1:0] BB_PAD_SPLIT = 2'b10;

    localparam int BB_FXP   = 6;
    localparam int BB_HGT   = 3;
    localparam int BB_REG_W = 36;
    localparam int BB_OUT_W = 40;

endpackage

// File: rtl/bankbuff_row_pad.sv
// rtl/bankbuff_row_pad.sv - combinational zero-padder widening one REG_W row to OUT_W elements
module bankbuff_row_pad
    import bankbuff_win_pkg::*;
#(
    parameter int FXP   = BB_FXP,
    parameter int REG_W = BB_REG_W,
    parameter int OUT_W = BB_OUT_W
) (
    input  logic [REG_W*FXP-1:0] row_in,
    input  logic [1:0]           pad_mode,
    output logic [OUT_W*FXP-1:0] row_out
);

    localparam int PAD = OUT_W - REG_W;

    generate
        if (PAD < 0) begin : g_bad_width
            $error("bankbuff_row_pad: OUT_W must be >= REG_W");
        end
    endgenerate

    logic [OUT_W*FXP-1:0] ext;

    // Zero-extend once, then the mode only selects how far the row moves up.
    always_comb begin
        ext = '0;
        ext[REG_W*FXP-1:0] = row_in;
        case (pad_mode)
            BB_PAD_RIGHT: row_out = ext;
            BB_PAD_SPLIT: row_out = ext << ((PAD / 2) * FXP);
            default:      row_out = ext << (PAD * FXP);
        endcase
    end

endmodule

// File: rtl/bankbuff_win.sv
// rtl/bankbuff_win.sv - HGT-row shift chain with registered padded window output and back-pressure
// Optional stride-2 window decimation under `define BANKBUFF_WIN_STRIDE_EN.
module bankbuff_win
    import bankbuff_win_pkg::*;
#(
    parameter int FXP   = BB_FXP,
    parameter int HGT   = BB_HGT,
    parameter int REG_W = BB_REG_W,
    parameter int OUT_W = BB_OUT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [REG_W*FXP-1:0]       in_row,
    input  logic [1:0]                 pad_mode,
`ifdef BANKBUFF_WIN_STRIDE_EN
    input  logic                       stride,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [HGT*OUT_W*FXP-1:0]   out_win,
    output logic [$clog2(HGT+1)-1:0]   fill_cnt
);

    localparam int RW = REG_W * FXP;
    localparam int OW = OUT_W * FXP;
    localparam int FW = $clog2(HGT + 1);

    logic [RW-1:0]        row_q [HGT];
    logic [RW-1:0]        row_d [HGT];
    logic [RW-1:0]        shift_row [HGT];
    logic [OW-1:0]        pad_row [HGT];
    logic [HGT*OW-1:0]    out_win_q, out_win_d;
    logic                 out_valid_q, out_valid_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic                 push, pop, full_after, gen_ok;
`ifdef BANKBUFF_WIN_STRIDE_EN
    logic                 phase_q, phase_d;
`endif

    // Padders see the chain as it will be after a push, so the window loads in the same edge.
    assign shift_row[0] = in_row;
    genvar g;
    generate
        for (g = 1; g < HGT; g++) begin : g_shift
            assign shift_row[g] = row_q[g-1];
        end
        for (g = 0; g < HGT; g++) begin : g_pad
            bankbuff_row_pad #(.FXP(FXP), .REG_W(REG_W), .OUT_W(OUT_W)) u_pad (
                .row_in   (shift_row[HGT-1-g]),
                .pad_mode (pad_mode),
                .row_out  (pad_row[g])
            );
        end
    endgenerate

    assign in_ready   = ~out_valid_q | out_ready;
    assign push       = in_valid & in_ready;
    assign pop        = out_valid_q & out_ready;
    assign full_after = (32'(fill_q) + 1) >= HGT;

    always_comb begin
        gen_ok = 1'b1;
`ifdef BANKBUFF_WIN_STRIDE_EN
        phase_d = phase_q;
        if (32'(fill_q) < HGT) begin
            phase_d = 1'b0;
        end else if (push) begin
            phase_d = ~phase_q;
        end
        // Once full, stride 2 keeps only every second push.
        gen_ok = ~stride | (32'(fill_q) < HGT) | phase_q;
`endif
        row_d       = row_q;
        fill_d      = fill_q;
        out_win_d   = out_win_q;
        out_valid_d = out_valid_q;
        if (push) begin
            row_d = shift_row;
            if (32'(fill_q) < HGT) begin
                fill_d = fill_q + FW'(1);
            end
        end
        if (push && full_after && gen_ok) begin
            out_valid_d = 1'b1;
            for (int j = 0; j < HGT; j++) begin
                out_win_d[j*OW +: OW] = pad_row[j];
            end
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int k = 0; k < HGT; k++) begin
                row_q[k] <= '0;
            end
            out_win_q   <= '0;
            out_valid_q <= 1'b0;
            fill_q      <= '0;
`ifdef BANKBUFF_WIN_STRIDE_EN
            phase_q     <= 1'b0;
`endif
        end else begin
            row_q       <= row_d;
            out_win_q   <= out_win_d;
            out_valid_q <= out_valid_d;
            fill_q      <= fill_d;
`ifdef BANKBUFF_WIN_STRIDE_EN
            phase_q     <= phase_d;
`endif
        end
    end

    assign out_win   = out_win_q;
    assign out_valid = out_valid_q;
    assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_bankbuff_win.sv
// tb/tb_bankbuff_win.sv - self-checking bench for bankbuff_win with a queue-based window model
module tb_bankbuff_win;

    localparam int FXP = 4, HGT = 3, REG_W = 4, OUT_W = 6;
    localparam int RW = REG_W * FXP, OW = OUT_W * FXP, WW = HGT * OW, PAD = OUT_W - REG_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [RW-1:0] in_row = '0;
    logic [1:0]    pad_mode = 2'b00;
`ifdef BANKBUFF_WIN_STRIDE_EN
    logic          stride = 1'b0;
`endif
    logic          in_ready, out_valid;
    logic [WW-1:0] out_win;
    logic [1:0]    fill_cnt;

    always #5 clk = ~clk;

    bankbuff_win #(.FXP(FXP), .HGT(HGT), .REG_W(REG_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .pad_mode  (pad_mode),
`ifdef BANKBUFF_WIN_STRIDE_EN
        .stride    (stride),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_win   (out_win),
        .fill_cnt  (fill_cnt)
    );

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: newest row at the queue front; window slice j is the j-th oldest row, padded element-wise.
    logic [RW-1:0] hist[$];
    bit            m_valid = 1'b0;
    logic [WW-1:0] m_win = '0;
    int            m_since = 0;
    bit            chk_en = 1'b0;

    function automatic logic [OW-1:0] pad_fn(input logic [RW-1:0] r, input logic [1:0] mode);
        int lowz;
        logic [OW-1:0] o;
        o = '0;
        lowz = (mode == 2'b01) ? 0 : (mode == 2'b10) ? PAD / 2 : PAD;
        for (int e = 0; e < REG_W; e++) o[(e + lowz) * FXP +: FXP] = r[e * FXP +: FXP];
        return o;
    endfunction

    always @(posedge clk) begin
        bit push, pop, gen;
        push = in_valid && (!m_valid || out_ready);
        pop  = m_valid && out_ready;
        gen  = 1'b0;
        if (rst || clr) begin
            hist.delete();
            m_valid = 1'b0;
            m_win   = '0;
            m_since = 0;
        end else begin
            if (push) begin
                hist.push_front(in_row);
                if (hist.size() > HGT) void'(hist.pop_back());
                if (hist.size() == HGT) begin
                    gen = 1'b1;
`ifdef BANKBUFF_WIN_STRIDE_EN
                    if (stride && (m_since % 2) != 0) gen = 1'b0;
`endif
                    m_since++;
                end
                if (gen)
                    for (int j = 0; j < HGT; j++) m_win[j * OW +: OW] = pad_fn(hist[HGT - 1 - j], pad_mode);
            end
            if (gen) m_valid = 1'b1;
            else if (pop) m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_out_valid", WW'(out_valid), WW'(m_valid));
            check("cyc_in_ready", WW'(in_ready), WW'(!m_valid || out_ready));
            check("cyc_fill_cnt", WW'(fill_cnt), WW'(hist.size()));
            check("cyc_out_win", out_win, m_win);
        end
    end

    task automatic push_row(input logic [RW-1:0] r, input logic [1:0] m);
        in_valid = 1'b1;
        in_row   = r;
        pad_mode = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [WW-1:0] held;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst = 1'b0;
        check("rst_fill", WW'(fill_cnt), WW'(0));
        check("rst_valid", WW'(out_valid), WW'(0));
        check("rst_win", out_win, '0);
        check("rst_in_ready", WW'(in_ready), WW'(1));

        out_ready = 1'b1;
        push_row(16'h1111, 2'b00);
        check("fill1_valid", WW'(out_valid), WW'(0));
        check("fill1_cnt", WW'(fill_cnt), WW'(1));
        push_row(16'h2222, 2'b00);
        check("fill2_valid", WW'(out_valid), WW'(0));
        check("fill2_cnt", WW'(fill_cnt), WW'(2));
        push_row(16'h3333, 2'b00);
        check("fill3_valid", WW'(out_valid), WW'(1));
        check("fill3_cnt", WW'(fill_cnt), WW'(3));
        check("fill3_win", out_win, 72'h333300_222200_111100);
        step();
        check("fill_pop_valid", WW'(out_valid), WW'(0));
        check("pop_hold_win", out_win, 72'h333300_222200_111100);

        push_row(16'h4444, 2'b01);
        check("right_win", out_win, 72'h004444_003333_002222);
        push_row(16'h5555, 2'b10);
        out_ready = 1'b0;
        check("split_win", out_win, 72'h055550_044440_033330);

        held = out_win;
        in_valid = 1'b1;
        in_row   = 16'h6666;
        pad_mode = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            pad_mode = (i % 2 == 0) ? 2'b00 : 2'b01;
            check("bp_in_ready", WW'(in_ready), WW'(0));
            check("bp_valid", WW'(out_valid), WW'(1));
            check("bp_win", out_win, held);
            check("bp_fill", WW'(fill_cnt), WW'(3));
        end
        pad_mode  = 2'b01;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("bp_release_win", out_win, 72'h006666_005555_004444);
        check("bp_release_valid", WW'(out_valid), WW'(1));
        step();

        clr = 1'b1;
        step();
        clr = 1'b0;
        push_row(16'h1234, 2'b00);
        push_row(16'h5678, 2'b00);
        check("clr_pre_fill", WW'(fill_cnt), WW'(2));
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_fill", WW'(fill_cnt), WW'(0));
        check("clr_valid", WW'(out_valid), WW'(0));
        check("clr_win", out_win, '0);
        push_row(16'h0102, 2'b00);
        check("clr_p1_valid", WW'(out_valid), WW'(0));
        push_row(16'h0304, 2'b00);
        check("clr_p2_valid", WW'(out_valid), WW'(0));
        push_row(16'h0506, 2'b00);
        check("clr_p3_valid", WW'(out_valid), WW'(1));
        check("clr_p3_win", out_win, 72'h050600_030400_010200);
        step();

        rst = 1'b1;
        clr = 1'b1;
        in_valid = 1'b1;
        in_row = 16'hBEEF;
        step();
        rst = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        check("prio_fill", WW'(fill_cnt), WW'(0));
        check("prio_valid", WW'(out_valid), WW'(0));
        check("prio_win", out_win, '0);
        push_row(16'h0A0B, 2'b00);
        push_row(16'h0C0D, 2'b00);
        check("prio_fill2", WW'(fill_cnt), WW'(2));
        check("prio_valid2", WW'(out_valid), WW'(0));
        push_row(16'h0E0F, 2'b10);
        check("prio_win3", out_win, 72'h00E0F0_00C0D0_00A0B0);
        step();

`ifdef BANKBUFF_WIN_STRIDE_EN
        clr = 1'b1;
        step();
        clr = 1'b0;
        stride = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            push_row(RW'(i * 16'h1111), 2'b00);
            check("stride_valid", WW'(out_valid), WW'(i == 3 || i == 5 || i == 7));
        end
        stride = 1'b0;
        step();
`endif

        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bankbuff_win.md
Name: bankbuff_win

Overview:
- Parametrised vertical row-window buffer feeding the MAC cone; successor to the fixed-height bank buffer.
- Accepts one image row per valid/ready handshake into a HGT-deep shift chain.
- Emits a registered HGT-row window with per-window selectable zero-padding (left/right/split).
- Adds fill tracking and output back-pressure; sits between the bank SRAM read port and the MAC array.

Parameters:
- FXP, 6, bits per fixed-point element
- HGT, 3, rows per window (MAC cone height)
- REG_W, 36, elements per input row
- OUT_W, 40, elements per output row; PAD = OUT_W-REG_W, must be >=0 (elaboration error otherwise)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clr  in  1  synchronous soft clear (frame start)
- in_valid  in  1  row valid
- in_ready  out  1  buffer can accept row
- in_row  in  REG_W*FXP  input row, element 0 in LSBs
- pad_mode  in  2  sampled on push: 00 left, 01 right, 10 split, 11 treated as 00
- out_valid  out  1  window available
- out_ready  in  1  consumer accepts window
- out_win  out  HGT*OUT_W*FXP  window; slice 0 = oldest row, slice HGT-1 = newest
- fill_cnt  out  $clog2(HGT+1)  rows held, saturates at HGT

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: rst=1 clears row chain, out_win, fill_cnt and out_valid to 0; in_ready=1 from the next cycle.
- Precedence: rst > clr > push/pop. clr has identical effect to rst.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = ~out_valid | out_ready, combinational. Push and pop in the same cycle is legal.
- On push:
  - row[k] <= row[k-1]; row[0] <= in_row.
  - fill_cnt increments, saturating at HGT.
- Window generation:
  - If (fill_cnt+1) >= HGT on a push, out_win is loaded next edge from the post-shift chain with padding applied.
  - out_valid is set.
  - Latency: push at edge t → window visible after edge t (one cycle).
- On pop without push: out_valid clears; out_win holds its last value.
- While out_valid=1 and out_ready=0:
  - out_win and out_valid are stable.
  - in_ready=0, so no push occurs and the chain is frozen.
- Padding per output row (PAD zero elements):
  - 00 left: row occupies MSBs, zeros in low PAD*FXP bits.
  - 01 right: row occupies LSBs, zeros in high bits.
  - 10 split: floor(PAD/2) zero elements in LSBs, ceil(PAD/2) in MSBs.
  - PAD=0: all modes pass the row through unchanged.
- pad_mode is captured only at the loading push. A change while out_valid is held does not alter out_win.

Optional Feature:
- Macro: BANKBUFF_WIN_STRIDE_EN.
- When defined:
  - Adds input port stride (1 bit; 0 = stride 1, 1 = stride 2), sampled on every push.
  - Adds a 1-bit phase toggle, cleared by rst/clr and whenever fill_cnt < HGT.
  - With stride=1 the behaviour is identical to the undefined case.
  - With stride=2, after the first full window, a window is generated only on every second push (phase=1).
  - Pushes with phase=0 shift the chain without setting out_valid.
- When undefined: no stride port; every push at fill generates a window.

Decomposition:
- Shared header constants: BB_PAD_LEFT=2'b00, BB_PAD_RIGHT=2'b01, BB_PAD_SPLIT=2'b10; defaults for FXP/HGT/REG_W/OUT_W.
- One sub-module, bankbuff_row_pad: combinational per-row padder (REG_W*FXP in, pad_mode in, OUT_W*FXP out), instantiated HGT times in a generate loop.
- Chain, fill counter, handshake and stride logic stay in bankbuff_win.

Test Plan (FXP=4, HGT=3, REG_W=4, OUT_W=6):
- Fill:
  - Push rows 0x1111, 0x2222, 0x3333 with mode 00 and out_ready=1.
  - out_valid is 0 after pushes 1–2; after push 3, out_valid=1 for one cycle.
  - out_win = {0x333300, 0x222200, 0x111100}; fill_cnt = 1, 2, 3.
- Padding modes: push 0x4444 with mode 01 → newest slice 0x004444. Push 0x5555 with mode 10 → newest slice 0x055550.
- Back-pressure:
  - Hold out_ready=0 with a window pending and in_valid=1 for 5 cycles.
  - in_ready=0; out_win and out_valid are stable; fill_cnt is unchanged.
  - Raise out_ready → push and pop complete in the same cycle, and the new window appears next cycle.
- Mid-operation clear: assert clr with fill_cnt=2 → next cycle fill_cnt=0, out_valid=0, out_win=0. The following 3 pushes are needed before out_valid.
- Reset priority: assert rst and clr together while pushing → state is the reset state, and the pushed row is discarded.
- Stride (macro defined, stride=1 input i.e. stride 2): push 7 rows → windows after pushes 3, 5, 7 only.
